// File: rtl/n4_b10_down_timer.sv
// 4-digit BCD countdown timer. A loaded value counts down to 0000, one step per
// tick while running. Reaching zero produces a one-cycle done pulse and then
// either stops or reloads the last loaded value.
module n4_b10_down_timer #(
  parameter bit AUTORELOAD = 1'b0
) (
  input  logic       clock,
  input  logic       reset_,
  input  logic       load,
  input  logic [3:0] d33_d30,
  input  logic [3:0] d23_d20,
  input  logic [3:0] d13_d10,
  input  logic [3:0] d03_d00,
  input  logic       start,
  input  logic       stop,
  input  logic       tick,
  output logic [3:0] q33_q30,
  output logic [3:0] q23_q20,
  output logic [3:0] q13_q10,
  output logic [3:0] q03_q00,
  output logic       running,
  output logic       done
);

  typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

  state_e state_q, state_d;

  // Digit 3 is thousands, digit 0 is units.
  logic [3:0][3:0] cnt_q, cnt_d;
  logic [3:0][3:0] rld_q, rld_d;
  logic [3:0][3:0] load_val;
  logic [3:0][3:0] dec_val;
  logic            borrow;
  logic            done_q, done_d;
  logic            running_q;
  logic            cnt_zero;
  logic            dec_zero;
  logic            rld_zero;

  function automatic logic [3:0] clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // Clamp load digits and form the BCD decrement of the current count.
  always_comb begin
    load_val[3] = clamp9(d33_d30);
    load_val[2] = clamp9(d23_d20);
    load_val[1] = clamp9(d13_d10);
    load_val[0] = clamp9(d03_d00);
    borrow      = 1'b1;
    dec_val     = cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (borrow) begin
        if (cnt_q[i] == 4'd0) begin
          dec_val[i] = 4'd9;
        end else begin
          dec_val[i] = cnt_q[i] - 4'd1;
          borrow     = 1'b0;
        end
      end
    end
  end

  assign cnt_zero = (cnt_q == '0);
  assign dec_zero = (dec_val == '0);
  assign rld_zero = (rld_q == '0);

  // State, count, reload and registered status outputs.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rld_q     <= '0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rld_q     <= rld_d;
      done_q    <= done_d;
      running_q <= (state_d == StRun);
    end
  end

  // Next-state and datapath decisions; stop always beats start and tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rld_d   = rld_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          cnt_d = load_val;
          rld_d = load_val;
        end else if (start && !stop && !cnt_zero) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (stop) begin
          state_d = StPause;
        end else if (tick) begin
          if (dec_zero) begin
            done_d = 1'b1;
            // A zero reload value would restart at 0000, so it stops instead.
            if (AUTORELOAD && !rld_zero) begin
              cnt_d = rld_q;
            end else begin
              cnt_d   = '0;
              state_d = StIdle;
            end
          end else begin
            cnt_d = dec_val;
          end
        end
      end
      StPause: begin
        if (load) begin
          cnt_d   = load_val;
          rld_d   = load_val;
          state_d = StIdle;
        end else if (start && !stop) begin
          state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Drive the ports straight from registers.
  always_comb begin
    q33_q30 = cnt_q[3];
    q23_q20 = cnt_q[2];
    q13_q10 = cnt_q[1];
    q03_q00 = cnt_q[0];
    running = running_q;
    done    = done_q;
  end

endmodule

// File: tb/tb_n4_b10_down_timer.sv
// Scoreboard bench for n4_b10_down_timer: the driver queues expected outputs,
// the monitor pops and compares them shortly after each falling clock edge.
module tb_n4_b10_down_timer;

  logic       clock;
  logic       reset_;
  logic       load, start, stop, tick;
  logic [3:0] d33_d30, d23_d20, d13_d10, d03_d00;
  logic [3:0] a_q3, a_q2, a_q1, a_q0, b_q3, b_q2, b_q1, b_q0;
  logic       a_run, a_done, b_run, b_done;

  n4_b10_down_timer #(.AUTORELOAD(1'b0)) u_dut0 (
    .clock(clock), .reset_(reset_), .load(load),
    .d33_d30(d33_d30), .d23_d20(d23_d20), .d13_d10(d13_d10), .d03_d00(d03_d00),
    .start(start), .stop(stop), .tick(tick),
    .q33_q30(a_q3), .q23_q20(a_q2), .q13_q10(a_q1), .q03_q00(a_q0),
    .running(a_run), .done(a_done)
  );

  n4_b10_down_timer #(.AUTORELOAD(1'b1)) u_dut1 (
    .clock(clock), .reset_(reset_), .load(load),
    .d33_d30(d33_d30), .d23_d20(d23_d20), .d13_d10(d13_d10), .d03_d00(d03_d00),
    .start(start), .stop(stop), .tick(tick),
    .q33_q30(b_q3), .q23_q20(b_q2), .q13_q10(b_q1), .q03_q00(b_q0),
    .running(b_run), .done(b_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Entry layout: {dut select, q[15:0], running, done}
  logic [18:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [18:0] m_exp;
  logic [17:0] m_act;
  string       m_name;

  always @(negedge clock or negedge reset_) begin
    #1;
    while (exp_q.size() > 0) begin
      m_exp  = exp_q.pop_front();
      m_name = name_q.pop_front();
      m_act  = m_exp[18] ? {b_q3, b_q2, b_q1, b_q0, b_run, b_done}
                         : {a_q3, a_q2, a_q1, a_q0, a_run, a_done};
      checks++;
      if (m_act !== m_exp[17:0]) begin
        errors++;
        $display("FAIL %s (dut%0d): got q=%h running=%b done=%b, expected q=%h running=%b done=%b",
                 m_name, m_exp[18], m_act[17:2], m_act[1], m_act[0],
                 m_exp[17:2], m_exp[1], m_exp[0]);
      end
    end
  end

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input bit sel, input string nm, input int v, input bit r, input bit d);
    exp_q.push_back({sel, to_bcd(v), r, d});
    name_q.push_back(nm);
  endtask

  // One clock cycle with the given inputs; returns just after the rising edge.
  task automatic cyc(input bit ld, input bit st, input bit sp, input bit tk,
                     input logic [15:0] dv);
    @(negedge clock);
    load = ld; start = st; stop = sp; tick = tk;
    {d33_d30, d23_d20, d13_d10, d03_d00} = dv;
    @(posedge clock);
    #1;
    load = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2;
    reset_ = 1'b0;
    chk(0, "reset", 0, 0, 0);
    chk(1, "reset", 0, 0, 0);
    @(negedge clock);
    reset_ = 1'b1;
  endtask

  initial begin
    reset_ = 1'b0;
    load = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0;
    {d33_d30, d23_d20, d13_d10, d03_d00} = 16'h0000;
    #3;
    chk(0, "por", 0, 0, 0);
    chk(1, "por", 0, 0, 0);
    @(negedge clock);
    reset_ = 1'b1;

    // Count 12 down to zero.
    cyc(1, 0, 0, 0, 16'h0012); chk(0, "load12", 12, 0, 0);
    cyc(0, 1, 0, 0, 16'h0000); chk(0, "start12", 12, 1, 0);
    for (int i = 1; i <= 12; i++) begin
      cyc(0, 0, 0, 1, 16'h0000); chk(0, "cnt12", 12 - i, i != 12, i == 12);
    end
    cyc(0, 0, 0, 0, 16'h0000); chk(0, "done_one_cycle", 0, 0, 0);
    cyc(0, 0, 0, 1, 16'h0000); chk(0, "tick_in_idle", 0, 0, 0);

    // Borrow ripple.
    cyc(1, 0, 0, 0, 16'h1000); chk(0, "load1000", 1000, 0, 0);
    cyc(0, 1, 0, 0, 16'h0000); chk(0, "start1000", 1000, 1, 0);
    cyc(0, 0, 0, 1, 16'h0000); chk(0, "ripple999", 999, 1, 0);
    cyc(0, 0, 1, 0, 16'h0000); chk(0, "pause999", 999, 0, 0);
    cyc(1, 0, 0, 0, 16'h0100); chk(0, "pause_load100", 100, 0, 0);
    cyc(0, 1, 0, 0, 16'h0000); chk(0, "start100", 100, 1, 0);
    cyc(0, 0, 0, 1, 16'h0000); chk(0, "ripple99", 99, 1, 0);
    cyc(0, 0, 1, 0, 16'h0000); chk(0, "pause99", 99, 0, 0);

    // Clamp and a full count-down from 9939.
    cyc(1, 0, 0, 0, 16'hFA3C); chk(0, "clamp", 9939, 0, 0);
    cyc(0, 1, 0, 0, 16'h0000); chk(0, "start9939", 9939, 1, 0);
    for (int n = 9938; n >= 0; n--) begin
      cyc(0, 0, 0, 1, 16'h0000); chk(0, "cnt9939", n, n != 0, n == 0);
    end
    cyc(0, 0, 0, 0, 16'h0000); chk(0, "done9939_end", 0, 0, 0);

    // Stop priority, pause/resume, load ignored in RUN.
    cyc(1, 0, 0, 0, 16'h0005); chk(0, "load5", 5, 0, 0);
    cyc(0, 1, 0, 0, 16'h0000); chk(0, "start5", 5, 1, 0);
    cyc(0, 0, 0, 1, 16'h0000); chk(0, "cnt4", 4, 1, 0);
    cyc(0, 0, 0, 1, 16'h0000); chk(0, "cnt3", 3, 1, 0);
    cyc(0, 0, 1, 1, 16'h0000); chk(0, "stop_over_tick", 3, 0, 0);
    cyc(0, 0, 0, 1, 16'h0000); chk(0, "tick_in_pause", 3, 0, 0);
    cyc(0, 1, 1, 0, 16'h0000); chk(0, "pause_start_stop", 3, 0, 0);
    cyc(0, 1, 0, 1, 16'h0000); chk(0, "resume_no_tick", 3, 1, 0);
    cyc(1, 0, 0, 0, 16'h0007); chk(0, "load_in_run", 3, 1, 0);
    cyc(0, 0, 0, 1, 16'h0000); chk(0, "cnt2", 2, 1, 0);
    cyc(0, 0, 0, 1, 16'h0000); chk(0, "cnt1", 1, 1, 0);
    cyc(0, 0, 0, 1, 16'h0000); chk(0, "cnt0_done", 0, 0, 1);
    cyc(0, 0, 0, 0, 16'h0000); chk(0, "done_clear", 0, 0, 0);

    // Simultaneous-input priorities.
    cyc(1, 1, 0, 0, 16'h0002); chk(0, "idle_load_start", 2, 0, 0);
    cyc(0, 1, 1, 0, 16'h0000); chk(0, "idle_start_stop", 2, 0, 0);
    cyc(0, 1, 1, 0, 16'h0000); chk(0, "idle_start_stop2", 2, 0, 0);
    cyc(0, 1, 0, 0, 16'h0000); chk(0, "start2", 2, 1, 0);
    cyc(0, 1, 1, 1, 16'h0000); chk(0, "run_start_stop", 2, 0, 0);
    cyc(1, 1, 0, 0, 16'h0008); chk(0, "pause_load_start", 8, 0, 0);
    cyc(0, 0, 0, 1, 16'h0000); chk(0, "idle_after_load", 8, 0, 0);

    // Autoreload on the second instance.
    do_reset();
    cyc(1, 0, 0, 0, 16'h0003); chk(1, "ar_load3", 3, 0, 0);
    cyc(0, 1, 0, 0, 16'h0000); chk(1, "ar_start", 3, 1, 0);
    begin
      int seq[7] = '{2, 1, 3, 2, 1, 3, 2};
      for (int i = 0; i < 7; i++) begin
        cyc(0, 0, 0, 1, 16'h0000); chk(1, "ar_cnt", seq[i], 1, (i == 2) || (i == 5));
      end
    end

    // Start from zero is ignored; asynchronous reset mid-count.
    do_reset();
    cyc(0, 1, 0, 0, 16'h0000); chk(0, "start_zero", 0, 0, 0);
    cyc(1, 0, 0, 0, 16'h0050); chk(0, "load50", 50, 0, 0);
    cyc(0, 1, 0, 0, 16'h0000); chk(0, "start50", 50, 1, 0);
    for (int i = 1; i <= 5; i++) begin
      cyc(0, 0, 0, 1, 16'h0000); chk(0, "cnt50", 50 - i, 1, 0);
    end
    @(negedge clock);
    #2;
    reset_ = 1'b0;
    chk(0, "async_reset", 0, 0, 0);
    @(negedge clock);
    reset_ = 1'b1;

    // Reset right after the terminal edge cancels the done pulse.
    cyc(1, 0, 0, 0, 16'h0001); chk(0, "load1", 1, 0, 0);
    cyc(0, 1, 0, 0, 16'h0000); chk(0, "start1", 1, 1, 0);
    cyc(0, 0, 0, 1, 16'h0000);
    #1;
    reset_ = 1'b0;
    chk(0, "reset_cancels_done", 0, 0, 0);
    @(negedge clock);
    reset_ = 1'b1;

    repeat (3) @(negedge clock);
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/n4_b10_down_timer.md
Name: n4_b10_down_timer

Overview:
- 4-digit BCD countdown timer, the decrementing counterpart of the 4-digit base-10 up counter; counts a loaded value down to 0000 on an external tick enable.
- Reports completion with a one-cycle done pulse.
- Sits beside the up counter in the timing subsystem; the tick typically comes from a prescaler or from an up counter's carry-out.

Parameters:
AUTORELOAD, 0, 1 = on reaching 0000 reload the last loaded value and keep running; 0 = stop at 0000

Ports:
clock  input  1  system clock, all state updates on rising edge
reset_  input  1  asynchronous active-low reset
load  input  1  capture d33_d30..d03_d00 as new count and reload value
d33_d30  input  4  load value, thousands digit (BCD)
d23_d20  input  4  load value, hundreds digit
d13_d10  input  4  load value, tens digit
d03_d00  input  4  load value, units digit
start  input  1  begin or resume counting
stop  input  1  pause counting
tick  input  1  count enable: one decrement per cycle with tick=1 while running
q33_q30  output  4  current count, thousands digit
q23_q20  output  4  current count, hundreds digit
q13_q10  output  4  current count, tens digit
q03_q00  output  4  current count, units digit
running  output  1  1 while in RUN
done  output  1  one-cycle pulse when the count reaches 0000 by decrement

Behaviour:
- Reset (reset_=0, asynchronous): all q digits = 0, reload register = 0, state IDLE, running = 0, done = 0. Release takes effect on the next clock edge.
- States: IDLE, RUN, PAUSE. The running output is registered and equals (state == RUN).
- Load clamp: each loaded digit greater than 9 is clamped to 9 in both q and the reload register.
- IDLE
  - load=1: q and reload register take the clamped digits; stay IDLE.
  - start=1, load=0, q != 0000: go to RUN.
  - start=1 with q == 0000: ignored; stay IDLE.
- RUN
  - load: ignored.
  - stop=1: go to PAUSE; q holds. A tick in the same cycle is ignored, because stop has priority.
  - tick=1, stop=0: decrement q by one in BCD.
    - The units digit decrements; 0 wraps to 9 with a borrow to the tens digit; the borrow ripples the same way through hundreds and thousands.
    - Each digit stays within 0..9 at all times.
- Reaching zero (a decrement produces 0000):
  - done=1 in the cycle following that edge, for exactly one cycle.
  - AUTORELOAD=0: q = 0000, go to IDLE, running=0.
  - AUTORELOAD=1: instead of writing 0000, q takes the reload value on that edge and the state stays RUN. done still pulses for one cycle, and q never shows 0000.
  - AUTORELOAD=1 with reload value 0000: the decrement that reaches 0000 leaves q at 0000 and goes to IDLE, exactly as AUTORELOAD=0.
- PAUSE
  - start=1: return to RUN. A tick in the same cycle is not applied; counting resumes on the next tick.
  - load=1: new value loaded and state goes to IDLE. load has priority over start.
  - stop: no effect.
- Simultaneous inputs
  - In IDLE, load and start together: load applied, start ignored.
  - start and stop together in any state: stop wins; RUN goes to PAUSE, IDLE and PAUSE are unchanged.
- Latency: q changes on the clock edge where tick is sampled, with no added pipeline stage. done is registered: 1 cycle after the terminal edge.
- Reset asserted mid-count: immediate return to the reset values; any pending done pulse is cancelled.
- tick outside RUN has no effect. done is never asserted by load, stop or reset.

Test Plan:
- Reset, load 0012, start, 12 ticks -> q steps 0011, 0010, 0009, …, 0001, 0000; done pulses for one cycle; running falls to 0; state IDLE.
- Load 1000, start, 1 tick -> q = 0999; load 0100, 1 tick -> 0099. Checks borrow ripple across all digits.
- Load digits 0xF,0xA,0x3,0xC -> q = 9939; start plus continuous ticks; check no digit ever exceeds 9; done after 9939 ticks.
- Load 0005, start, 2 ticks, assert stop and tick together -> q stays 0003, PAUSE; load ignored-check: start, then load 0007 in RUN -> q unaffected; 3 ticks -> done, q = 0000.
- AUTORELOAD=1: load 0003, start, 7 ticks -> q sequence 2,1,3,2,1,3,2; done pulses after ticks 3 and 6; running stays 1; q never 0000.
- Start with q=0000 -> stays IDLE, running=0; load 0050, start, 5 ticks, assert reset_=0 asynchronously between edges -> q = 0000, running = 0, done = 0 immediately.
